// File: rtl/fft_seq_ctrl_pkg.sv
// Shared types and address helper for the runtime-sized radix-2 DIT FFT sequencer.
// Butterfly addressing is computed at a fixed 16-bit width; users slice to their own widths.
package fft_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int LOG2N_MIN = 3;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] tw;
    } bfly_t;

    // Butterfly j of stage s: operands straddle a span of 2^s, twiddle stride shrinks as s grows.
    function automatic bfly_t bfly_addr(input logic [15:0] j, input logic [3:0] s,
                                        input logic [3:0] log2n_max);
        bfly_t       r;
        logic [15:0] half;
        logic [15:0] pos;
        logic [15:0] grp;
        half = 16'd1 << s;
        pos  = j & (half - 16'd1);
        grp  = j >> s;
        r.a  = (grp << (s + 4'd1)) | pos;
        r.b  = r.a + half;
        r.tw = pos << (log2n_max - 4'd1 - s);
        return r;
    endfunction

endpackage

// File: rtl/fft_seq_ctrl_if.sv
// Control/address bundle between the FFT sequencer (slave) and its host/datapath (master).
// The stall_i input exists only when FFT_SEQ_STALL_EN is defined.
interface fft_seq_ctrl_if #(
    parameter int LOG2N_MAX = 10
);
    localparam int AW = LOG2N_MAX;
    localparam int TW = LOG2N_MAX - 1;

    logic          start_i;
    logic [3:0]    log2n_cfg_i;
    logic          abort_i;
`ifdef FFT_SEQ_STALL_EN
    logic          stall_i;
`endif
    logic          busy_o;
    logic          done_o;
    logic          cfg_err_o;
    logic          result_bank_o;
    logic [3:0]    stage_o;
    logic          rd_en_o;
    logic          rd_bank_o;
    logic [AW-1:0] rd_addr_a_o;
    logic [AW-1:0] rd_addr_b_o;
    logic [TW-1:0] tw_addr_o;
    logic          wr_en_o;
    logic          wr_bank_o;
    logic [AW-1:0] wr_addr_a_o;
    logic [AW-1:0] wr_addr_b_o;

    modport master (
`ifdef FFT_SEQ_STALL_EN
        output stall_i,
`endif
        output start_i, log2n_cfg_i, abort_i,
        input  busy_o, done_o, cfg_err_o, result_bank_o, stage_o,
        input  rd_en_o, rd_bank_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o,
        input  wr_en_o, wr_bank_o, wr_addr_a_o, wr_addr_b_o
    );

    modport slave (
`ifdef FFT_SEQ_STALL_EN
        input  stall_i,
`endif
        input  start_i, log2n_cfg_i, abort_i,
        output busy_o, done_o, cfg_err_o, result_bank_o, stage_o,
        output rd_en_o, rd_bank_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o,
        output wr_en_o, wr_bank_o, wr_addr_a_o, wr_addr_b_o
    );

endinterface

// File: rtl/fft_seq_ctrl_delay_line.sv
// Fixed-depth shift register that turns read-issue fields into write-issue fields
// after the butterfly latency; a synchronous flush drops every in-flight entry.
module fft_seq_ctrl_delay_line #(
    parameter int W     = 22,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o
);
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [W-1:0] stage_q;
            logic [W-1:0] stage_d;
            if (gi == 0) begin : g_head
                assign stage_d = din_i;
            end else begin : g_tail
                assign stage_d = g_stage[gi-1].stage_q;
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_q <= '0;
                end else if (flush_i) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= stage_d;
                end
            end
        end
    endgenerate

    assign dout_o = g_stage[DEPTH-1].stage_q;

endmodule

// File: rtl/fft_seq_ctrl.sv
// Runtime-sized radix-2 DIT in-place FFT sequencer: issues butterfly read/write addresses,
// twiddle indices and ping-pong bank selects. Optional issue stall: define FFT_SEQ_STALL_EN.
module fft_seq_ctrl
    import fft_seq_ctrl_pkg::*;
#(
    parameter int LOG2N_MAX = 10,
    parameter int BFLY_LAT  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    fft_seq_ctrl_if.slave bus
);
    localparam int AW = LOG2N_MAX;
    localparam int TW = LOG2N_MAX - 1;
    localparam int CW = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
    localparam int DW = 2 + 2 * AW;

    state_t        state_q;
    logic [3:0]    log2n_q;
    logic [3:0]    s_q;
    logic [AW-2:0] j_q;
    logic [CW-1:0] drain_cnt_q;
    logic          busy_q;
    logic          done_q;
    logic          cfg_err_q;
    logic          result_bank_q;
    logic          rd_en_q;
    logic          rd_bank_q;
    logic [AW-1:0] rd_addr_a_q;
    logic [AW-1:0] rd_addr_b_q;
    logic [TW-1:0] tw_addr_q;

    bfly_t         bfly_d;
    logic          stall_d;
    logic          j_last_d;
    logic          s_last_d;
    logic          cfg_ok_d;
    logic [DW-1:0] dly_in_d;
    logic [DW-1:0] dly_out_d;
    logic          unused_bfly_bits;

`ifdef FFT_SEQ_STALL_EN
    assign stall_d = bus.stall_i;
`else
    assign stall_d = 1'b0;
`endif

    assign bfly_d   = bfly_addr(16'(j_q), s_q, 4'(LOG2N_MAX));
    assign j_last_d = (16'(j_q) == ((16'd1 << (log2n_q - 4'd1)) - 16'd1));
    assign s_last_d = (s_q == (log2n_q - 4'd1));
    assign cfg_ok_d = (bus.log2n_cfg_i >= 4'(LOG2N_MIN)) && (bus.log2n_cfg_i <= 4'(LOG2N_MAX));
    assign unused_bfly_bits = ^{bfly_d.a[15:AW], bfly_d.b[15:AW], bfly_d.tw[15:TW]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            log2n_q       <= '0;
            s_q           <= '0;
            j_q           <= '0;
            drain_cnt_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
            result_bank_q <= 1'b0;
            rd_en_q       <= 1'b0;
            rd_bank_q     <= 1'b0;
            rd_addr_a_q   <= '0;
            rd_addr_b_q   <= '0;
            tw_addr_q     <= '0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            rd_en_q   <= 1'b0;
            // Abort outranks everything, including a start arriving in the same cycle.
            if (bus.abort_i) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (bus.start_i) begin
                            if (cfg_ok_d) begin
                                state_q <= ST_RUN;
                                busy_q  <= 1'b1;
                                log2n_q <= bus.log2n_cfg_i;
                                s_q     <= '0;
                                j_q     <= '0;
                            end else begin
                                cfg_err_q <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (!stall_d) begin
                            rd_en_q     <= 1'b1;
                            rd_bank_q   <= s_q[0];
                            rd_addr_a_q <= bfly_d.a[AW-1:0];
                            rd_addr_b_q <= bfly_d.b[AW-1:0];
                            tw_addr_q   <= bfly_d.tw[TW-1:0];
                            if (j_last_d) begin
                                j_q         <= '0;
                                drain_cnt_q <= '0;
                                state_q     <= ST_DRAIN;
                            end else begin
                                j_q <= j_q + 1'b1;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        // Hold off the next stage until its first read sees the last write.
                        if (drain_cnt_q == CW'(BFLY_LAT - 1)) begin
                            if (s_last_d) begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                            end else begin
                                s_q     <= s_q + 4'd1;
                                state_q <= ST_RUN;
                            end
                        end else begin
                            drain_cnt_q <= drain_cnt_q + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        done_q        <= 1'b1;
                        result_bank_q <= log2n_q[0];
                        state_q       <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign dly_in_d = {rd_en_q, ~rd_bank_q, rd_addr_a_q, rd_addr_b_q};

    fft_seq_ctrl_delay_line #(
        .W     (DW),
        .DEPTH (BFLY_LAT)
    ) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (bus.abort_i),
        .din_i   (dly_in_d),
        .dout_o  (dly_out_d)
    );

    assign {bus.wr_en_o, bus.wr_bank_o, bus.wr_addr_a_o, bus.wr_addr_b_o} = dly_out_d;

    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign bus.cfg_err_o     = cfg_err_q;
    assign bus.result_bank_o = result_bank_q;
    assign bus.stage_o       = s_q;
    assign bus.rd_en_o       = rd_en_q;
    assign bus.rd_bank_o     = rd_bank_q;
    assign bus.rd_addr_a_o   = rd_addr_a_q;
    assign bus.rd_addr_b_o   = rd_addr_b_q;
    assign bus.tw_addr_o     = tw_addr_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Self-checking bench for fft_seq_ctrl: table of directed runs plus randomized runs, each
// checked against a reference that enumerates butterflies by index bit and predicts timing.
module tb_fft_seq_ctrl;
    localparam int LMAX = 10;
    localparam int LAT  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_seq_ctrl_if #(.LOG2N_MAX(LMAX)) bus ();

    fft_seq_ctrl #(.LOG2N_MAX(LMAX), .BFLY_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int cyc;
        int s;
        int a;
        int b;
        int tw;
        int bank;
    } xact_t;

    typedef struct {
        string name;
        int    cfg;
        int    abort_at;
        int    xstart_at;
        int    stall_at;
        int    stall_len;
        int    exp_done;
        int    exp_rb;
    } vec_t;

    int    checks = 0;
    int    failures = 0;
    xact_t rdq[$];
    xact_t wrq[$];
    int    touched[LMAX][1 << LMAX];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic drive_stall(input bit v);
`ifdef FFT_SEQ_STALL_EN
        bus.stall_i = v;
`else
        if (v) $display("note: stall requested without stall support");
`endif
    endtask

    // One complete run: build expected read/write streams, drive start at edge 0, then sample
    // after every edge c until the run has settled. exp_done/exp_rb of -2 mean "from the model".
    task automatic run_case(input string name, input int cfg, input int abort_at, input int xstart_at,
                            input int stall_at, input int stall_len, input int exp_done, input int exp_rb);
        xact_t x;
        bit    run_ok;
        bit    exp_busy;
        int    n, t, model_done, end_cyc, exp_err;
        int    done_cnt, done_cyc, rb_seen, err_cnt, err_cyc;
        int    busy_bad, rd_cnt, wr_cnt, cov_bad;

        run_ok = (cfg >= 3) && (cfg <= LMAX) && (abort_at != 0);
        exp_err = (!((cfg >= 3) && (cfg <= LMAX)) && (abort_at != 0)) ? 1 : 0;
        rdq.delete();
        wrq.delete();
        for (int s = 0; s < LMAX; s++)
            for (int a = 0; a < (1 << LMAX); a++) touched[s][a] = 0;
        model_done = -1;
        n = 1 << cfg;
        if (run_ok) begin
            t = 0;
            for (int s = 0; s < cfg; s++) begin
                for (int a = 0; a < n; a++) begin
                    if (((a >> s) & 1) == 0) begin
                        t++;
                        while (t >= stall_at && t < stall_at + stall_len) t++;
                        x.cyc  = t;
                        x.s    = s;
                        x.a    = a;
                        x.b    = a + (1 << s);
                        x.tw   = (a % (1 << s)) << (LMAX - 1 - s);
                        x.bank = s % 2;
                        if (abort_at < 0 || t < abort_at) rdq.push_back(x);
                        x.cyc  = t + LAT;
                        x.bank = 1 - x.bank;
                        if (abort_at < 0 || x.cyc < abort_at) wrq.push_back(x);
                    end
                end
                t += LAT;
            end
            model_done = t + 1;
        end
        if (exp_done == -2) exp_done = (run_ok && abort_at < 0) ? model_done : -1;
        if (exp_rb == -2) exp_rb = cfg % 2;
        end_cyc = !run_ok ? 6 : ((abort_at > 0) ? abort_at + LAT + 4 : model_done + 3);

        done_cnt = 0; done_cyc = -1; rb_seen = -1; err_cnt = 0; err_cyc = -1;
        busy_bad = 0; rd_cnt = 0; wr_cnt = 0;

        @(negedge clk);
        bus.log2n_cfg_i = 4'(cfg);
        bus.start_i     = 1'b1;
        bus.abort_i     = (abort_at == 0);
        drive_stall(1'b0);
        for (int c = 0; c <= end_cyc; c++) begin
            @(posedge clk);
            @(negedge clk);
            exp_busy = run_ok && (c < model_done - 1) && (abort_at < 0 || c < abort_at);
            if (bus.busy_o !== exp_busy) busy_bad++;
            if (bus.rd_en_o === 1'b1) begin
                rd_cnt++;
                if (rdq.size() == 0) begin
                    check($sformatf("%s unexpected_rd@%0d", name, c), bus.rd_addr_a_o, -1);
                end else begin
                    x = rdq.pop_front();
                    check($sformatf("%s rd%0d cycle", name, rd_cnt), c, x.cyc);
                    check($sformatf("%s rd%0d addr_a", name, rd_cnt), bus.rd_addr_a_o, x.a);
                    check($sformatf("%s rd%0d addr_b", name, rd_cnt), bus.rd_addr_b_o, x.b);
                    check($sformatf("%s rd%0d tw", name, rd_cnt), bus.tw_addr_o, x.tw);
                    check($sformatf("%s rd%0d bank", name, rd_cnt), bus.rd_bank_o, x.bank);
                    check($sformatf("%s rd%0d stage", name, rd_cnt), bus.stage_o, x.s);
                    touched[x.s][bus.rd_addr_a_o]++;
                    touched[x.s][bus.rd_addr_b_o]++;
                end
            end
            if (bus.wr_en_o === 1'b1) begin
                wr_cnt++;
                if (wrq.size() == 0) begin
                    check($sformatf("%s unexpected_wr@%0d", name, c), bus.wr_addr_a_o, -1);
                end else begin
                    x = wrq.pop_front();
                    check($sformatf("%s wr%0d cycle", name, wr_cnt), c, x.cyc);
                    check($sformatf("%s wr%0d addr_a", name, wr_cnt), bus.wr_addr_a_o, x.a);
                    check($sformatf("%s wr%0d addr_b", name, wr_cnt), bus.wr_addr_b_o, x.b);
                    check($sformatf("%s wr%0d bank", name, wr_cnt), bus.wr_bank_o, x.bank);
                end
            end
            if (bus.done_o === 1'b1) begin
                done_cnt++;
                done_cyc = c;
                rb_seen  = int'(bus.result_bank_o);
            end
            if (bus.cfg_err_o === 1'b1) begin
                err_cnt++;
                err_cyc = c;
            end
            bus.start_i = (c + 1 == xstart_at);
            bus.abort_i = (c + 1 == abort_at);
            drive_stall((c + 1 >= stall_at) && (c + 1 < stall_at + stall_len));
        end
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        drive_stall(1'b0);

        check({name, " reads_missing"}, rdq.size(), 0);
        check({name, " writes_missing"}, wrq.size(), 0);
        check({name, " done_count"}, done_cnt, (exp_done >= 0) ? 1 : 0);
        check({name, " done_cycle"}, done_cyc, exp_done);
        if (exp_done >= 0) check({name, " result_bank"}, rb_seen, exp_rb);
        check({name, " cfg_err_count"}, err_cnt, exp_err);
        if (exp_err == 1) check({name, " cfg_err_cycle"}, err_cyc, 0);
        check({name, " busy_mismatch_cycles"}, busy_bad, 0);
        if (exp_done >= 0) begin
            cov_bad = 0;
            for (int s = 0; s < cfg; s++)
                for (int a = 0; a < n; a++)
                    if (touched[s][a] != 1) cov_bad++;
            check({name, " addr_coverage"}, cov_bad, 0);
        end
        $display("run %-16s cfg=%0d abort=%0d reads=%0d writes=%0d done_cyc=%0d cfg_err=%0d",
                 name, cfg, abort_at, rd_cnt, wr_cnt, done_cyc, err_cnt);
    endtask

    vec_t vecs[9];
    int   nvec;

    initial begin
        int cfg, n, sat, slen, dn, ab, xs, done_cnt;

        bus.start_i     = 1'b0;
        bus.abort_i     = 1'b0;
        bus.log2n_cfg_i = 4'd0;
        drive_stall(1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        check("reset busy", bus.busy_o, 0);
        check("reset done", bus.done_o, 0);
        check("reset cfg_err", bus.cfg_err_o, 0);
        check("reset result_bank", bus.result_bank_o, 0);
        check("reset rd_en", bus.rd_en_o, 0);
        check("reset wr_en", bus.wr_en_o, 0);
        check("reset stage", bus.stage_o, 0);
        check("reset addr_or", int'(|{bus.rd_addr_a_o, bus.rd_addr_b_o, bus.tw_addr_o,
                                     bus.wr_addr_a_o, bus.wr_addr_b_o, bus.rd_bank_o, bus.wr_bank_o}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        vecs[0] = '{"cfg3",             3, -1, -1, -1, 0,   25, 1};
        vecs[1] = '{"cfg10",           10, -1, -1, -1, 0, 5161, 0};
        vecs[2] = '{"cfg2_err",         2, -1, -1, -1, 0,   -1, 0};
        vecs[3] = '{"cfg11_err",       11, -1, -1, -1, 0,   -1, 0};
        vecs[4] = '{"abort_stage1",     3, 10, -1, -1, 0,   -1, 0};
        vecs[5] = '{"after_abort",      3, -1, -1, -1, 0,   25, 1};
        vecs[6] = '{"start_midrun",     4, -1,  7, -1, 0,   49, 0};
        vecs[7] = '{"start_abort_idle", 5,  0, -1, -1, 0,   -1, 0};
        nvec = 8;
`ifdef FFT_SEQ_STALL_EN
        vecs[8] = '{"stall3_stage0",    3, -1, -1,  2, 3,   28, 1};
        nvec = 9;
`endif
        for (int i = 0; i < nvec; i++)
            run_case(vecs[i].name, vecs[i].cfg, vecs[i].abort_at, vecs[i].xstart_at,
                     vecs[i].stall_at, vecs[i].stall_len, vecs[i].exp_done, vecs[i].exp_rb);

        // Randomized runs: size, mid-run start, optional abort and (if built in) a stage-0 stall.
        for (int r = 0; r < 8; r++) begin
            cfg = int'($urandom_range(9, 2));
            if (cfg == 9) cfg = 11;
            n = 1 << cfg;
            sat = -1;
            slen = 0;
`ifdef FFT_SEQ_STALL_EN
            if (cfg >= 3 && $urandom_range(1, 0) == 1) begin
                sat  = int'($urandom_range(n / 2, 2));
                slen = int'($urandom_range(3, 1));
            end
`endif
            dn = 1 + cfg * (n / 2 + LAT) + slen;
            ab = -1;
            xs = -1;
            if (cfg >= 3) begin
                xs = int'($urandom_range(dn - 2, 1));
                if ($urandom_range(3, 0) == 0) ab = int'($urandom_range(dn - 1, 1));
                if (ab > 0 && xs >= ab) xs = -1;
            end
            run_case($sformatf("rand%0d", r), cfg, ab, xs, sat, slen, -2, -2);
        end

        // Async reset mid-run: outputs drop before the next clock edge, and no done follows.
        @(negedge clk);
        bus.log2n_cfg_i = 4'd5;
        bus.start_i     = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst busy", bus.busy_o, 0);
        check("async_rst rd_en", bus.rd_en_o, 0);
        check("async_rst wr_en", bus.wr_en_o, 0);
        check("async_rst stage", bus.stage_o, 0);
        check("async_rst addr_or", int'(|{bus.rd_addr_a_o, bus.rd_addr_b_o, bus.wr_addr_a_o}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1 || bus.rd_en_o === 1'b1) done_cnt++;
        end
        check("async_rst no_activity", done_cnt, 0);
        run_case("post_reset", 3, -1, -1, -1, 0, 25, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
